// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: one req/ack transaction per load/store,
// holding data_ready_mem low to freeze the pipeline until the access completes or times out.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread_mem,
  input  logic        memwrite_mem,
  input  logic [31:0] alu_result_mem,
  input  logic [31:0] write_data_memory_mem,
  output logic [31:0] data_from_memory_mem,
  output logic        data_ready_mem,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err_timeout,
  output logic        err_misaligned
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             access;
  logic             cnt_last;

  assign access   = memread_mem | memwrite_mem;
  assign cnt_last = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    data_ready_mem = 1'b1;
    case (state)
      IDLE: begin
        if (access) begin
          state_nxt      = BUSY;
          data_ready_mem = 1'b0;
        end
      end
      BUSY: begin
        data_ready_mem = 1'b0;
        if (mem_ack || cnt_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Pipeline must never be frozen while the unit is held in reset.
    if (rst) begin
      data_ready_mem = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req              <= 1'b0;
      mem_we               <= 1'b0;
      mem_addr             <= '0;
      mem_wdata            <= '0;
      data_from_memory_mem <= '0;
      cnt                  <= '0;
      err_timeout          <= 1'b0;
      err_misaligned       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            mem_req   <= 1'b1;
            mem_we    <= memwrite_mem;
            mem_addr  <= {alu_result_mem[31:2], 2'b00};
            mem_wdata <= write_data_memory_mem;
            cnt       <= '0;
            if (alu_result_mem[1:0] != 2'b00) begin
              err_misaligned <= 1'b1;
            end
          end
        end
        BUSY: begin
          // An ack in the final allowed cycle still completes the access normally.
          if (mem_ack) begin
            mem_req              <= 1'b0;
            data_from_memory_mem <= mem_we ? 32'h0 : mem_rdata;
          end else if (cnt_last) begin
            mem_req              <= 1'b0;
            data_from_memory_mem <= 32'h0;
            err_timeout          <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit (TIMEOUT=4): directed scenarios plus randomized accesses
// compared against a per-access model of latency, bus fields, returned data and error flags.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memread_mem = 1'b0;
  logic        memwrite_mem = 1'b0;
  logic [31:0] alu_result_mem = '0;
  logic [31:0] write_data_memory_mem = '0;
  logic [31:0] data_from_memory_mem;
  logic        data_ready_mem;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        err_timeout;
  logic        err_misaligned;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int req_rises = 0;
  logic prev_req = 1'b0;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .memread_mem(memread_mem),
    .memwrite_mem(memwrite_mem),
    .alu_result_mem(alu_result_mem),
    .write_data_memory_mem(write_data_memory_mem),
    .data_from_memory_mem(data_from_memory_mem),
    .data_ready_mem(data_ready_mem),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .err_timeout(err_timeout),
    .err_misaligned(err_misaligned)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mem_req && !prev_req) req_rises++;
    prev_req = mem_req;
  end

  typedef struct packed {
    int n_req;
    int n_stall;
    int total;
    int first_req;
    int last_req;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] dout;
    logic we;
    bit stable;
    bit ok;
    logic [7:0] dr_seq;
  } obs_t;

  // Applies one MEM-stage instruction at posedge+1, plays the memory side and records
  // what the bus and pipeline saw; returns at posedge+1 of the cycle after DONE.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd_in, input logic [31:0] rdata,
                            input int ack_at, input bit late_ack, output obs_t o);
    int c;
    bit done;
    o = '0;
    o.stable = 1'b1;
    memread_mem = rd;
    memwrite_mem = wr;
    alu_result_mem = addr;
    write_data_memory_mem = wd_in;
    mem_ack = 1'b0;
    c = 0;
    done = 1'b0;
    @(negedge clk);
    o.dr_seq[0] = data_ready_mem;
    if (!data_ready_mem) o.n_stall++;
    while (!done && c < 40) begin
      @(posedge clk);
      #1;
      c++;
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (mem_req && (o.n_req + 1 == ack_at)) begin
        mem_ack = 1'b1;
        mem_rdata = rdata;
      end else if (!mem_req && o.n_req > 0 && late_ack) begin
        mem_ack = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
      end
      @(negedge clk);
      if (c < 8) o.dr_seq[c[2:0]] = data_ready_mem;
      if (mem_req) begin
        if (o.n_req == 0) begin
          o.a = mem_addr;
          o.we = mem_we;
          o.wd = mem_wdata;
          o.first_req = cyc;
        end else if (mem_addr !== o.a || mem_we !== o.we || mem_wdata !== o.wd) begin
          o.stable = 1'b0;
        end
        o.n_req++;
        o.last_req = cyc;
      end
      if (data_ready_mem) begin
        done = 1'b1;
        o.dout = data_from_memory_mem;
      end else begin
        o.n_stall++;
      end
    end
    o.total = c + 1;
    o.ok = done;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    memread_mem = 1'b0;
    memwrite_mem = 1'b0;
    alu_result_mem = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    memread_mem = 1'b1;
    alu_result_mem = 32'h100;
    @(negedge clk);
    checks++; if (data_ready_mem !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", data_ready_mem); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
    checks++; if (data_from_memory_mem !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", data_from_memory_mem); end
    checks++; if ({err_timeout, err_misaligned} !== 2'b00) begin failures++; $display("FAIL reset_errs got=%b exp=00", {err_timeout, err_misaligned}); end
    memread_mem = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int r0;
    r0 = req_rises;
    for (int i = 0; i < 6; i++) begin
      alu_result_mem = $urandom;
      write_data_memory_mem = $urandom;
      @(negedge clk);
      checks++; if (data_ready_mem !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL idle_cycle%0d got ready=%b req=%b exp ready=1 req=0", i, data_ready_mem, mem_req); end
      @(posedge clk);
      #1;
    end
    checks++; if (req_rises !== r0) begin failures++; $display("FAIL idle_no_req got=%0d exp=%0d", req_rises, r0); end
  endtask

  task automatic test_load();
    obs_t o;
    run_access(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 2, 1'b0, o);
    checks++; if (!o.ok) begin failures++; $display("FAIL load_done got=timeout exp=done"); end
    checks++; if (o.n_req !== 2) begin failures++; $display("FAIL load_req_cycles got=%0d exp=2", o.n_req); end
    checks++; if (o.a !== 32'h100 || o.we !== 1'b0) begin failures++; $display("FAIL load_bus got addr=%h we=%b exp addr=00000100 we=0", o.a, o.we); end
    checks++; if (o.total !== 4 || o.dr_seq[3:0] !== 4'b1000) begin failures++; $display("FAIL load_ready_seq got total=%0d seq=%b exp total=4 seq=1000", o.total, o.dr_seq[3:0]); end
    checks++; if (o.dout !== 32'hDEADBEEF) begin failures++; $display("FAIL load_data got=%h exp=deadbeef", o.dout); end
    checks++; if (!o.stable) begin failures++; $display("FAIL load_stable got=changed exp=stable"); end
    checks++; if (err_misaligned !== 1'b0) begin failures++; $display("FAIL load_mis got=%b exp=0", err_misaligned); end
  endtask

  task automatic test_store_misaligned();
    obs_t o;
    run_access(1'b0, 1'b1, 32'h203, 32'h12345678, 32'h77777777, 1, 1'b0, o);
    checks++; if (!o.ok || o.n_req !== 1 || o.total !== 3) begin failures++; $display("FAIL store_timing got ok=%0b req=%0d total=%0d exp ok=1 req=1 total=3", o.ok, o.n_req, o.total); end
    checks++; if (o.a !== 32'h200) begin failures++; $display("FAIL store_addr got=%h exp=00000200", o.a); end
    checks++; if (o.we !== 1'b1 || o.wd !== 32'h12345678) begin failures++; $display("FAIL store_bus got we=%b wdata=%h exp we=1 wdata=12345678", o.we, o.wd); end
    checks++; if (o.dout !== 32'h0) begin failures++; $display("FAIL store_data got=%h exp=0", o.dout); end
    checks++; if (err_misaligned !== 1'b1) begin failures++; $display("FAIL store_mis got=%b exp=1", err_misaligned); end
  endtask

  task automatic test_back_to_back();
    obs_t o1;
    obs_t o2;
    int r0;
    r0 = req_rises;
    run_access(1'b1, 1'b0, 32'h40, 32'h0, 32'hA1B2C3D4, 1, 1'b0, o1);
    run_access(1'b0, 1'b1, 32'h44, 32'h0BADCAFE, 32'h0, 1, 1'b0, o2);
    checks++; if (o1.n_req !== 1 || o2.n_req !== 1) begin failures++; $display("FAIL b2b_req_cycles got=%0d,%0d exp=1,1", o1.n_req, o2.n_req); end
    checks++; if (o2.first_req - o1.last_req !== 3) begin failures++; $display("FAIL b2b_gap got=%0d exp=3", o2.first_req - o1.last_req); end
    checks++; if (o1.dout !== 32'hA1B2C3D4 || o2.a !== 32'h44 || o2.we !== 1'b1) begin failures++; $display("FAIL b2b_fields got d=%h a=%h we=%b", o1.dout, o2.a, o2.we); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    checks++; if (req_rises - r0 !== 2) begin failures++; $display("FAIL b2b_req_phases got=%0d exp=2", req_rises - r0); end
    checks++; if (err_misaligned !== 1'b1) begin failures++; $display("FAIL b2b_mis_sticky got=%b exp=1", err_misaligned); end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_access(1'b1, 1'b0, 32'h300, 32'h0, 32'hCAFEF00D, 0, 1'b1, o);
    checks++; if (!o.ok || o.n_req !== TO) begin failures++; $display("FAIL timeout_req_cycles got ok=%0b req=%0d exp ok=1 req=%0d", o.ok, o.n_req, TO); end
    checks++; if (o.total !== TO + 2) begin failures++; $display("FAIL timeout_total got=%0d exp=%0d", o.total, TO + 2); end
    checks++; if (o.dout !== 32'h0) begin failures++; $display("FAIL timeout_data got=%h exp=0", o.dout); end
    checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL timeout_flag got=%b exp=1", err_timeout); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || data_ready_mem !== 1'b1 || data_from_memory_mem !== 32'h0) begin failures++; $display("FAIL timeout_late_ack got req=%b ready=%b data=%h exp 0 1 0", mem_req, data_ready_mem, data_from_memory_mem); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_store_both();
    obs_t o;
    run_access(1'b1, 1'b0, 32'h84, 32'h0, 32'h5555AAAA, 1, 1'b0, o);
    checks++; if (o.dout !== 32'h5555AAAA) begin failures++; $display("FAIL both_pre_load got=%h exp=5555aaaa", o.dout); end
    run_access(1'b1, 1'b1, 32'h80, 32'hA5A5A5A5, 32'h11111111, 3, 1'b0, o);
    checks++; if (o.we !== 1'b1 || o.wd !== 32'hA5A5A5A5 || o.n_req !== 3) begin failures++; $display("FAIL both_bus got we=%b wd=%h req=%0d exp we=1 wd=a5a5a5a5 req=3", o.we, o.wd, o.n_req); end
    checks++; if (o.dout !== 32'h0) begin failures++; $display("FAIL both_data got=%h exp=0", o.dout); end
    @(negedge clk);
    checks++; if (data_from_memory_mem !== 32'h0) begin failures++; $display("FAIL both_hold got=%h exp=0", data_from_memory_mem); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    obs_t o;
    bit mdl_mis;
    bit mdl_to;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    mdl_mis = 1'b0;
    mdl_to = 1'b0;
    for (int i = 0; i < 24; i++) begin
      logic rd, wr;
      logic [31:0] addr, wd, rdata, exp_data;
      int op, ack_at, k;
      bit timed;
      op = $urandom_range(0, 2);
      rd = (op != 1);
      wr = (op != 0);
      addr = $urandom;
      if ($urandom_range(0, 5) != 0) addr[1:0] = 2'b00;
      else addr[1:0] = 2'($urandom_range(1, 3));
      wd = $urandom;
      rdata = $urandom;
      ack_at = $urandom_range(1, TO + 1);
      timed = (ack_at > TO);
      k = timed ? TO : ack_at;
      exp_data = (wr || timed) ? 32'h0 : rdata;
      if (addr[1:0] != 2'b00) mdl_mis = 1'b1;
      if (timed) mdl_to = 1'b1;
      run_access(rd, wr, addr, wd, rdata, ack_at, 1'b0, o);
      checks++; if (!o.ok) begin failures++; $display("FAIL rand%0d_done got=timeout exp=done", i); end
      checks++; if (o.n_req !== k) begin failures++; $display("FAIL rand%0d_req got=%0d exp=%0d", i, o.n_req, k); end
      checks++; if (o.n_stall !== k + 1 || o.total !== k + 2) begin failures++; $display("FAIL rand%0d_latency got stall=%0d total=%0d exp %0d %0d", i, o.n_stall, o.total, k + 1, k + 2); end
      checks++; if (o.a !== {addr[31:2], 2'b00}) begin failures++; $display("FAIL rand%0d_addr got=%h exp=%h", i, o.a, {addr[31:2], 2'b00}); end
      checks++; if (o.we !== wr) begin failures++; $display("FAIL rand%0d_we got=%b exp=%b", i, o.we, wr); end
      checks++; if (o.wd !== wd) begin failures++; $display("FAIL rand%0d_wdata got=%h exp=%h", i, o.wd, wd); end
      checks++; if (!o.stable) begin failures++; $display("FAIL rand%0d_stable got=changed exp=stable", i); end
      checks++; if (o.dout !== exp_data) begin failures++; $display("FAIL rand%0d_data got=%h exp=%h", i, o.dout, exp_data); end
      checks++; if (err_misaligned !== mdl_mis) begin failures++; $display("FAIL rand%0d_mis got=%b exp=%b", i, err_misaligned, mdl_mis); end
      checks++; if (err_timeout !== mdl_to) begin failures++; $display("FAIL rand%0d_to got=%b exp=%b", i, err_timeout, mdl_to); end
    end
  endtask

  task automatic test_reset_in_busy();
    obs_t o;
    memread_mem = 1'b1;
    alu_result_mem = 32'h501;
    @(posedge clk);
    #1;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rstbusy_req_before got=%b exp=1", mem_req); end
    rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || data_ready_mem !== 1'b1) begin failures++; $display("FAIL rstbusy_async got req=%b ready=%b exp req=0 ready=1", mem_req, data_ready_mem); end
    checks++; if ({err_timeout, err_misaligned} !== 2'b00) begin failures++; $display("FAIL rstbusy_errs got=%b exp=00", {err_timeout, err_misaligned}); end
    memread_mem = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || data_ready_mem !== 1'b1) begin failures++; $display("FAIL rstbusy_after got req=%b ready=%b exp req=0 ready=1", mem_req, data_ready_mem); end
    @(posedge clk);
    #1;
    run_access(1'b1, 1'b0, 32'h600, 32'h0, 32'h600D600D, 1, 1'b0, o);
    checks++; if (!o.ok || o.n_req !== 1 || o.dout !== 32'h600D600D) begin failures++; $display("FAIL rstbusy_recover got ok=%0b req=%0d data=%h exp 1 1 600d600d", o.ok, o.n_req, o.dout); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_load();
    test_store_misaligned();
    test_back_to_back();
    test_timeout();
    test_load_store_both();
    test_random();
    test_reset_in_busy();
    test_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
